// File: rtl/imuldiv_div_iter_ctrl_pkg.sv
// Shared encodings for the iterative restoring divider control path:
// FSM states, datapath mux-select constants and the default operand width.
package imuldiv_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic A_SEL_INIT    = 1'b0;
  localparam logic A_SEL_ITER    = 1'b1;
  localparam logic B_SEL_INIT    = 1'b0;
  localparam logic B_SEL_HOLD    = 1'b1;
  localparam logic SUB_SEL_SHIFT = 1'b0;
  localparam logic SUB_SEL_SUB   = 1'b1;

  typedef struct packed {
    logic a_mux_sel;
    logic b_mux_sel;
    logic sub_mux_sel;
    logic a_en;
    logic b_en;
    logic fn_en;
  } div_ctrl_t;

endpackage

// File: rtl/imuldiv_div_iter_ctrl_if.sv
// Request/response val-rdy handshakes between a divider client and the
// divider control unit.
interface imuldiv_div_iter_ctrl_if;

  logic divreq_val;
  logic divreq_rdy;
  logic divresp_val;
  logic divresp_rdy;

  modport master (
    output divreq_val,
    input  divreq_rdy,
    input  divresp_val,
    output divresp_rdy
  );

  modport slave (
    input  divreq_val,
    output divreq_rdy,
    output divresp_val,
    input  divresp_rdy
  );

endinterface

// File: rtl/imuldiv_div_iter_counter.sv
// Loadable down-counter tracking remaining shift-subtract steps; it saturates
// at zero so a stray decrement can never wrap it.
module imuldiv_div_iter_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: cnt_d gets a default before any branch so the comb block never infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments; reset is asynchronous so the
  // counter clears even without a running clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imuldiv_div_iter_ctrl.sv
// Control FSM for the iterative restoring divider: handshakes, WIDTH-step
// iteration sequencing and all datapath select/enable decode.
module imuldiv_div_iter_ctrl
  import imuldiv_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  imuldiv_div_iter_ctrl_if.slave  div_if,
  input  logic                    diff_msb,
  output logic                    a_mux_sel,
  output logic                    b_mux_sel,
  output logic                    sub_mux_sel,
  output logic                    a_en,
  output logic                    b_en,
  output logic                    fn_en,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e state_q;
  div_state_e state_d;
  div_ctrl_t  ctrl;
  logic       req_rdy;
  logic       req_fire;
  logic       cnt_zero;

  // DONE accepts a new request in the same cycle the response retires.
  assign req_rdy  = (state_q == IDLE) || ((state_q == DONE) && div_if.divresp_rdy);
  assign req_fire = div_if.divreq_val && req_rdy;

  imuldiv_div_iter_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (req_fire),
    .load_val_i (CNT_W'(WIDTH - 1)),
    .dec_i      (state_q == CALC),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_fire) state_d = CALC;
      CALC:    if (cnt_zero) state_d = DONE;
      DONE:    if (div_if.divresp_rdy) state_d = div_if.divreq_val ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl               = '0;
    div_if.divreq_rdy  = req_rdy;
    div_if.divresp_val = 1'b0;
    busy               = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        div_if.divresp_val = (state_q == DONE);
        busy               = (state_q == DONE);
        if (req_fire) begin
          ctrl.a_en      = 1'b1;
          ctrl.b_en      = 1'b1;
          ctrl.fn_en     = 1'b1;
          ctrl.a_mux_sel = A_SEL_INIT;
          ctrl.b_mux_sel = B_SEL_INIT;
        end
      end
      CALC: begin
        busy             = 1'b1;
        ctrl.a_en        = 1'b1;
        ctrl.a_mux_sel   = A_SEL_ITER;
        ctrl.b_mux_sel   = B_SEL_HOLD;
        // diff_msb is only consulted here, so an X elsewhere stays contained.
        ctrl.sub_mux_sel = diff_msb ? SUB_SEL_SHIFT : SUB_SEL_SUB;
      end
      default: ;
    endcase
  end

  assign a_mux_sel   = ctrl.a_mux_sel;
  assign b_mux_sel   = ctrl.b_mux_sel;
  assign sub_mux_sel = ctrl.sub_mux_sel;
  assign a_en        = ctrl.a_en;
  assign b_en        = ctrl.b_en;
  assign fn_en       = ctrl.fn_en;

endmodule

// File: tb/tb_imuldiv_div_iter_ctrl.sv
// Bench for the divider control unit, paired with a behavioural restoring
// datapath; results are compared with plain signed division.
module tb_imuldiv_div_iter_ctrl;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic diff_msb;
  logic a_mux_sel, b_mux_sel, sub_mux_sel, a_en, b_en, fn_en, busy;

  imuldiv_div_iter_ctrl_if dif ();

  imuldiv_div_iter_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .div_if      (dif),
    .diff_msb    (diff_msb),
    .a_mux_sel   (a_mux_sel),
    .b_mux_sel   (b_mux_sel),
    .sub_mux_sel (sub_mux_sel),
    .a_en        (a_en),
    .b_en        (b_en),
    .fn_en       (fn_en),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] op_a, op_b;
  logic        force_x  = 1'b0;
  logic        pat_mode = 1'b0;
  logic        pat_bit  = 1'b0;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

  // Behavioural restoring datapath steered only by the DUT's control outputs.
  logic [64:0] dp_a, dp_b;
  logic        dp_sq, dp_sr;
  logic [64:0] dp_sh, dp_diff;
  assign dp_sh   = {dp_a[63:0], 1'b0};
  assign dp_diff = dp_sh - dp_b;

  always_comb begin
    if (force_x)       diff_msb = 1'bx;
    else if (pat_mode) diff_msb = pat_bit;
    else               diff_msb = dp_diff[64];
  end

  always @(posedge clk) begin
    if (a_en) dp_a <= a_mux_sel ? (sub_mux_sel ? {dp_diff[64:1], 1'b1} : dp_sh)
                                : {33'b0, mag(op_a)};
    if (b_en && !b_mux_sel) dp_b <= {1'b0, mag(op_b), 32'b0};
    if (fn_en) begin
      dp_sq <= op_a[31] ^ op_b[31];
      dp_sr <= op_a[31];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] out_vec();
    return {dif.divreq_rdy, dif.divresp_val, a_en, b_en, fn_en,
            a_mux_sel, b_mux_sel, sub_mux_sel, busy};
  endfunction

  function automatic logic [8:0] exp_o(input bit rdy, val, ae, be, fe, as, bs, ss, bz);
    return {rdy, val, ae, be, fe, as, bs, ss, bz};
  endfunction

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r, eq, er;
    q  = dp_sq ? -dp_a[31:0]  : dp_a[31:0];
    r  = dp_sr ? -dp_a[63:32] : dp_a[63:32];
    eq = 32'($signed(a) / $signed(b));
    er = 32'($signed(a) % $signed(b));
    check({tag, "_quot"}, 64'(q), 64'(eq));
    check({tag, "_rem"},  64'(r), 64'(er));
  endtask

  // Called just after a falling edge with the DUT able to accept.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit in_done);
    op_a = a;
    op_b = b;
    dif.divreq_val = 1'b1;
    #1;
    check("load_ctrl", 64'(out_vec()), 64'(exp_o(1, in_done, 1, 1, 1, 0, 0, 0, in_done)));
  endtask

  // Steps through the iteration phase until divresp_val, bounded.
  task automatic wait_resp(input bit hold_req, input bit use_pat, output int lat);
    int iters;
    lat   = 0;
    iters = 0;
    do begin
      @(negedge clk);
      lat++;
      force_x  = 1'b0;
      pat_mode = use_pat;
      if (!hold_req) dif.divreq_val = 1'b0;
      if (use_pat) pat_bit = 1'($urandom_range(0, 1));
      #1;
      if (a_en && a_mux_sel) iters++;
      if (!dif.divresp_val && lat < 200)
        check("calc_ctrl", 64'(out_vec()), 64'(exp_o(0, 0, 1, 0, 0, 1, 1, ~diff_msb, 1)));
    end while (!dif.divresp_val && lat < 200);
    pat_mode = 1'b0;
    check("resp_latency", 64'(lat), 64'(W + 1));
    check("calc_iters", 64'(iters), 64'(W));
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int stall, input bit use_pat, input bit xmode);
    int lat;
    dif.divresp_rdy = (stall == 0);
    force_x = xmode;
    issue(a, b, 1'b0);
    wait_resp(1'b0, use_pat, lat);
    force_x = xmode;
    #1;
    if (!use_pat) check_result(tag, a, b);
    if (stall == 0) begin
      check("done_ctrl", 64'(out_vec()), 64'(exp_o(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    end else begin
      for (int s = 0; s < stall; s++) begin
        if (s > 0) begin
          @(negedge clk);
          #1;
          if (!use_pat) check_result({tag, "_held"}, a, b);
        end
        check("stall_ctrl", 64'(out_vec()), 64'(exp_o(0, 1, 0, 0, 0, 0, 0, 0, 1)));
      end
      @(negedge clk);
      dif.divresp_rdy = 1'b1;
      #1;
      check("release_ctrl", 64'(out_vec()), 64'(exp_o(1, 1, 0, 0, 0, 0, 0, 0, 1)));
    end
    @(negedge clk);
    #1;
    check("idle_after", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    force_x = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] ra, rb;

    reset = 1'b0;
    dif.divreq_val  = 1'b0;
    dif.divresp_rdy = 1'b1;
    op_a = '0;
    op_b = 32'd1;

    // Reset raised mid-cycle before any clock edge acts immediately.
    #2 reset = 1'b1;
    #1 check("reset_async", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    reset = 1'b0;
    #1 check("idle_no_req", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);

    do_op("d20_3", 32'd20, 32'd3, 0, 1'b0, 1'b0);

    // Random diff_msb in CALC: sub_mux_sel must be its inverse each cycle.
    do_op("pattern", 32'd12345, 32'd17, 0, 1'b1, 1'b0);

    // Backpressure of 5 cycles with X on diff_msb outside CALC.
    do_op("stall5", 32'd77, 32'hFFFF_FFF7, 5, 1'b0, 1'b1);

    // Back-to-back with divreq_val held high across both operations.
    issue(32'd100, 32'd7, 1'b0);
    wait_resp(1'b1, 1'b0, lat);
    check_result("b2b_first", 32'd100, 32'd7);
    op_a = -32'sd100;
    op_b = 32'd7;
    #1 check("b2b_refire", 64'(out_vec()), 64'(exp_o(1, 1, 1, 1, 1, 0, 0, 0, 1)));
    wait_resp(1'b0, 1'b0, lat);
    check_result("b2b_second", -32'sd100, 32'd7);
    @(negedge clk);
    #1 check("b2b_idle", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));

    // Reset ten cycles into CALC discards the operation.
    @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dif.divreq_val = 1'b0;
    end
    #2 reset = 1'b1;
    #1 check("reset_mid_calc", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (c % 8 == 0 || dif.divresp_val || busy)
        check("post_reset_idle", 64'(out_vec()), 64'(exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    end
    do_op("d9_2", 32'd9, 32'd2, 0, 1'b0, 1'b0);

    // Random signed operands with random response backpressure.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0) rb = 32'($signed(rb) >>> $urandom_range(4, 28));
      if (rb == 32'd0) rb = 32'd5;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      do_op("rand", ra, rb, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
